hk_reader: RTL and testbench
============================

Name: hk_reader

Overview:
- Consumer-side sequencer for the H/K constant memory.
- Waits for the memory's ready flag, then on request fetches the 8 initial hash words H0..H7 into a 256-bit register.
- Streams the 64 round constants K0..K63 to the compression core over a valid/ready handshake, one block at a time.
- Sits between the H/K memory and the SHA-256 round datapath, and owns the memory's selector and address lines exclusively.

Parameters:
- RD_LAT, 2, cycles from a registered address change to HK_D being sampled; legal range 1..7.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous, active-low reset.
- HK_RDY  in  1  H/K memory has finished its ROM copy and is usable.
- HK_SEL  out  1  memory selector: 0 = H bank, 1 = K bank.
- H_ADDR  out  3  H word index.
- K_ADDR  out  6  K word index.
- HK_D  in  32  memory read data.
- START  in  1  request pulse; sampled only in IDLE.
- NEW_MSG  in  1  qualifies START; 1 = reload H before streaming K.
- BUSY  out  1  high in any state other than IDLE and WAIT_RDY.
- H_INIT  out  256  H0 in [255:224] through H7 in [31:0].
- H_VLD  out  1  H_INIT holds a complete, current set.
- K_OUT  out  32  current round constant.
- K_T  out  6  round index of K_OUT.
- K_VALID  out  1  K_OUT/K_T valid.
- K_READY  in  1  consumer accepts K_OUT.
- DONE  out  1  one-cycle pulse after K63 is accepted.
- ABORT  out  1  one-cycle pulse when HK_RDY falls during an operation.

Behaviour:
- Reset (RST=0 at a posedge):
  - state = WAIT_RDY.
  - HK_SEL = 0, H_ADDR = 0, K_ADDR = 0.
  - H_INIT = 0, K_OUT = 0, K_T = 0.
  - H_VLD, K_VALID, BUSY, DONE, ABORT all 0.
  - Reset has priority over every other event, including mid-fetch and mid-handshake.
- All outputs are registered.
- States:
  - WAIT_RDY: go to IDLE on the edge where HK_RDY = 1.
  - IDLE: on START=1 & NEW_MSG=1 → H_FETCH; H_VLD cleared; HK_SEL=0; H_ADDR=0; latency counter loaded with RD_LAT.
  - IDLE: on START=1 & NEW_MSG=0 & H_VLD=1 → K_FETCH; HK_SEL=1; K_ADDR=0.
  - IDLE: on START=1 & NEW_MSG=0 & H_VLD=0 → request ignored; state stays IDLE.
  - H_FETCH:
    - Latency counter decrements each cycle.
    - At the edge where it reaches 0: HK_D is written into word H_ADDR of H_INIT, H_ADDR increments and the counter reloads.
    - After word 7 is captured: H_VLD=1, HK_SEL=1, K_ADDR=0, → K_FETCH.
    - One H word per RD_LAT cycles.
  - K_FETCH: after RD_LAT cycles, K_OUT=HK_D, K_T=K_ADDR, K_VALID=1, → K_HOLD.
  - K_HOLD:
    - K_OUT and K_T stay stable while K_READY=0; there is no timeout.
    - On an edge with K_VALID & K_READY: K_VALID=0.
    - If K_T=63: DONE=1 for one cycle, HK_SEL=0, → IDLE.
    - Otherwise K_ADDR increments and the state goes to K_FETCH.
    - K throughput is at most one word per RD_LAT+1 cycles. A single read is outstanding at any time.
- HK_RDY low in any BUSY state:
  - Next edge: ABORT pulse, K_VALID=0, H_VLD=0, → WAIT_RDY.
  - A partial H_INIT must never be reported valid.
- START while BUSY: ignored and not queued.
- START coincident with HK_RDY falling in IDLE: the state goes to WAIT_RDY and START is dropped. No ABORT is raised, because no operation was in progress.
- Address wrap: H_ADDR and K_ADDR never wrap mid-operation; they are reset to 0 on entry to each phase.
- Address stability: H_ADDR, K_ADDR and HK_SEL change only at capture/phase edges, so memory data has RD_LAT full cycles to settle.

Decomposition:
- Shared package hk_pkg holds:
  - HK_SEL_H=0, HK_SEL_K=1.
  - N_H=8, N_K=64.
  - The state enum {WAIT_RDY, IDLE, H_FETCH, K_FETCH, K_HOLD}.
  - SHA-256 reference constants H0..H7 and K0..K63, for benches.
- One sub-module, hk_lat_timer: a loadable RD_LAT down-counter with a zero flag. It is reused by both fetch states.

Test Plan:
- RST=0 for 3 cycles, then release with HK_RDY=0 for 20 cycles → state WAIT_RDY, BUSY=0, all outputs 0, and START pulses have no effect.
- HK_RDY=1, START+NEW_MSG at edge 0, RD_LAT=2, K_READY=1 → H_VLD rises after edge 16 with H_INIT[255:224]=6a09e667 and H_INIT[31:0]=5be0cd19. First K_VALID has K_T=0, K_OUT=428a2f98. The last word is K_T=63, K_OUT=c67178f2, and DONE pulses exactly once.
- K_READY toggled randomly (≥30% low) → all 64 K words arrive in order, each held unchanged while K_READY=0, and no word is duplicated or skipped.
- Second block with START, NEW_MSG=0 → no H reads (HK_SEL stays 1 throughout), H_INIT and H_VLD unchanged, and 64 K words stream again.
- HK_RDY dropped during H word 4 fetch, and separately at K_T=20 → ABORT pulses for one cycle, H_VLD=0, K_VALID=0, state WAIT_RDY. On HK_RDY return plus START+NEW_MSG, the full sequence completes correctly.
- RST=0 asserted at K_T=37 with K_VALID=1 → all outputs are zero on the next edge. START with NEW_MSG=0 after recovery is ignored because H_VLD=0.

Source files
------------

// File: rtl/hk_pkg.sv
// Shared definitions for the H/K constant memory reader: bank selectors,
// table sizes, sequencer states and the SHA-256 reference constants.
package hk_pkg;

  localparam logic HK_SEL_H = 1'b0;
  localparam logic HK_SEL_K = 1'b1;

  localparam int N_H = 8;
  localparam int N_K = 64;

  typedef enum logic [2:0] {
    WAIT_RDY,
    IDLE,
    H_FETCH,
    K_FETCH,
    K_HOLD
  } hk_state_t;

  localparam logic [31:0] H_REF [N_H] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_REF [N_K] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/hk_lat_timer.sv
// Loadable read-latency down-counter shared by the H and K fetch phases.
// zero marks the cycle whose closing edge takes the count to zero.
module hk_lat_timer #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 3'(RD_LAT);
    end else if (en && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign zero = en && (cnt == 3'd1);

endmodule

// File: rtl/hk_reader.sv
// Consumer-side sequencer for the H/K constant memory: loads H0..H7 into
// H_INIT and streams K0..K63 to the round datapath over valid/ready.
//
// state    | meaning
// WAIT_RDY | memory not usable yet, requests ignored
// IDLE     | ready for START
// H_FETCH  | reading H0..H7, one word per RD_LAT cycles
// K_FETCH  | waiting RD_LAT cycles for the current K word
// K_HOLD   | K_OUT presented, waiting for K_READY
module hk_reader
  import hk_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         HK_RDY,
  output logic         HK_SEL,
  output logic [2:0]   H_ADDR,
  output logic [5:0]   K_ADDR,
  input  logic [31:0]  HK_D,
  input  logic         START,
  input  logic         NEW_MSG,
  output logic         BUSY,
  output logic [255:0] H_INIT,
  output logic         H_VLD,
  output logic [31:0]  K_OUT,
  output logic [5:0]   K_T,
  output logic         K_VALID,
  input  logic         K_READY,
  output logic         DONE,
  output logic         ABORT
);

  hk_state_t state;
  logic      tmr_load;
  logic      tmr_en;
  logic      tmr_zero;

  hk_lat_timer #(.RD_LAT(RD_LAT)) u_timer (
    .clk   (CLK),
    .rst_b (RST),
    .load  (tmr_load),
    .en    (tmr_en),
    .zero  (tmr_zero)
  );

  // The timer restarts whenever a new address is placed on the memory.
  always_comb begin
    tmr_en   = (state == H_FETCH) || (state == K_FETCH);
    tmr_load = 1'b0;
    case (state)
      IDLE:    tmr_load = HK_RDY && START && (NEW_MSG || H_VLD);
      H_FETCH: tmr_load = tmr_zero;
      K_HOLD:  tmr_load = K_VALID && K_READY && (K_T != 6'(N_K - 1));
      default: tmr_load = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= WAIT_RDY;
      HK_SEL  <= HK_SEL_H;
      H_ADDR  <= '0;
      K_ADDR  <= '0;
      H_INIT  <= '0;
      H_VLD   <= 1'b0;
      K_OUT   <= '0;
      K_T     <= '0;
      K_VALID <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ABORT   <= 1'b0;
    end else begin
      DONE  <= 1'b0;
      ABORT <= 1'b0;
      if (BUSY && !HK_RDY) begin
        // Memory went away mid-operation; a partial H set is never kept valid.
        state   <= WAIT_RDY;
        ABORT   <= 1'b1;
        K_VALID <= 1'b0;
        H_VLD   <= 1'b0;
        BUSY    <= 1'b0;
        HK_SEL  <= HK_SEL_H;
      end else begin
        case (state)
          WAIT_RDY: begin
            if (HK_RDY) state <= IDLE;
          end
          IDLE: begin
            if (!HK_RDY) begin
              state <= WAIT_RDY;
            end else if (START && NEW_MSG) begin
              state  <= H_FETCH;
              H_VLD  <= 1'b0;
              HK_SEL <= HK_SEL_H;
              H_ADDR <= '0;
              BUSY   <= 1'b1;
            end else if (START && H_VLD) begin
              state  <= K_FETCH;
              HK_SEL <= HK_SEL_K;
              K_ADDR <= '0;
              BUSY   <= 1'b1;
            end
          end
          H_FETCH: begin
            if (tmr_zero) begin
              H_INIT[{3'(N_H - 1) - H_ADDR, 5'd0} +: 32] <= HK_D;
              if (H_ADDR == 3'(N_H - 1)) begin
                state  <= K_FETCH;
                H_VLD  <= 1'b1;
                HK_SEL <= HK_SEL_K;
                K_ADDR <= '0;
              end else begin
                H_ADDR <= H_ADDR + 3'd1;
              end
            end
          end
          K_FETCH: begin
            if (tmr_zero) begin
              state   <= K_HOLD;
              K_OUT   <= HK_D;
              K_T     <= K_ADDR;
              K_VALID <= 1'b1;
            end
          end
          K_HOLD: begin
            if (K_VALID && K_READY) begin
              K_VALID <= 1'b0;
              if (K_T == 6'(N_K - 1)) begin
                state  <= IDLE;
                DONE   <= 1'b1;
                HK_SEL <= HK_SEL_H;
                BUSY   <= 1'b0;
              end else begin
                state  <= K_FETCH;
                K_ADDR <= K_ADDR + 6'd1;
              end
            end
          end
          default: state <= WAIT_RDY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hk_reader.sv
// Directed-plus-random bench for hk_reader with a latency-aware H/K memory
// model and an expected-sequence model of the K stream.
module tb_hk_reader;
  import hk_pkg::*;

  localparam int unsigned RD_LAT = 2;
  localparam int T_H    = 8 * RD_LAT;
  localparam int T_FULL = 8 * RD_LAT + 64 * (RD_LAT + 1);

  logic         CLK = 1'b0;
  logic         RST, HK_RDY, HK_SEL, START, NEW_MSG, BUSY, H_VLD;
  logic         K_VALID, K_READY, DONE, ABORT;
  logic [2:0]   H_ADDR;
  logic [5:0]   K_ADDR, K_T;
  logic [31:0]  HK_D, K_OUT;
  logic [255:0] H_INIT;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  logic [255:0] exp_h;

  logic [6:0] mem_key;
  logic [6:0] last_key = '1;
  int mem_age = 0;

  hk_reader #(.RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RST(RST), .HK_RDY(HK_RDY), .HK_SEL(HK_SEL),
    .H_ADDR(H_ADDR), .K_ADDR(K_ADDR), .HK_D(HK_D), .START(START),
    .NEW_MSG(NEW_MSG), .BUSY(BUSY), .H_INIT(H_INIT), .H_VLD(H_VLD),
    .K_OUT(K_OUT), .K_T(K_T), .K_VALID(K_VALID), .K_READY(K_READY),
    .DONE(DONE), .ABORT(ABORT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt++;

  // Memory returns garbage until the address has been stable RD_LAT cycles.
  always @(negedge CLK) begin
    mem_key = HK_SEL ? {1'b1, K_ADDR} : {4'b0000, H_ADDR};
    if (mem_key != last_key) mem_age = 1;
    else if (mem_age < 1000) mem_age++;
    last_key = mem_key;
    if (mem_age >= int'(RD_LAT)) HK_D = HK_SEL ? K_REF[K_ADDR] : H_REF[H_ADDR];
    else HK_D = 32'hdead_beef;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 256'({HK_SEL, H_ADDR, K_ADDR, H_VLD, K_T, K_VALID, BUSY, DONE, ABORT}), 256'(0));
    chk({tag, "_h_init"}, H_INIT, 256'(0));
    chk({tag, "_k_out"}, 256'(K_OUT), 256'(0));
  endtask

  task automatic pulse_start(input bit nm, output int e0);
    START = 1'b1;
    NEW_MSG = nm;
    @(negedge CLK);
    START = 1'b0;
    NEW_MSG = 1'b0;
    e0 = edge_cnt;
  endtask

  task automatic wait_h(input int e0, input string tag);
    int n;
    n = 0;
    while (H_VLD !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_hvld_edge"}, 256'(edge_cnt - e0), 256'(T_H));
    chk({tag, "_h_init"}, H_INIT, exp_h);
  endtask

  task automatic stream_k(input int low_pct, input int stop_kt, input bit k_only,
                          input bit poke, input string tag, output int done_edge);
    int exp_t;
    int cyc;
    int dones;
    int sel_bad;
    bit held;
    exp_t = 0; cyc = 0; dones = 0; sel_bad = 0; held = 1'b0;
    done_edge = -1;
    while (cyc < 4000) begin
      if (DONE === 1'b1) begin
        dones++;
        done_edge = edge_cnt;
        break;
      end
      if (k_only && HK_SEL !== 1'b1) sel_bad++;
      if (K_VALID === 1'b1) begin
        if (exp_t > 63) begin
          chk({tag, "_k_overrun"}, 256'(exp_t), 256'(63));
          break;
        end
        chk({tag, "_k_t"}, 256'(K_T), 256'(exp_t));
        chk({tag, "_k_out"}, 256'(K_OUT), 256'(K_REF[exp_t]));
        if (exp_t == stop_kt) begin
          K_READY = 1'b0;
          START = 1'b0;
          return;
        end
        K_READY = ($urandom_range(99) >= low_pct);
        if (K_READY) begin
          exp_t++;
          held = 1'b0;
        end else begin
          held = 1'b1;
        end
      end else begin
        if (held) begin
          chk({tag, "_valid_dropped"}, 256'(K_VALID), 256'(1));
          held = 1'b0;
        end
        K_READY = ($urandom_range(99) >= low_pct);
      end
      START = poke && ($urandom_range(3) == 0);
      NEW_MSG = 1'($urandom_range(1));
      @(negedge CLK);
      cyc++;
    end
    START = 1'b0;
    NEW_MSG = 1'b0;
    chk({tag, "_done_count"}, 256'(dones), 256'(1));
    chk({tag, "_words"}, 256'(exp_t), 256'(64));
    if (k_only) chk({tag, "_h_reads"}, 256'(sel_bad), 256'(0));
    @(negedge CLK);
    chk({tag, "_done_pulse"}, 256'(DONE), 256'(0));
    chk({tag, "_idle_after"}, 256'(BUSY), 256'(0));
  endtask

  initial begin
    int e0;
    int de;
    int n;
    for (int i = 0; i < N_H; i++) exp_h[255 - 32 * i -: 32] = H_REF[i];
    RST = 1'b0; HK_RDY = 1'b0; START = 1'b0; NEW_MSG = 1'b0; K_READY = 1'b0;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b1;

    // Memory not ready: START pulses must do nothing.
    for (int i = 0; i < 20; i++) begin
      START = 1'($urandom_range(1));
      NEW_MSG = 1'($urandom_range(1));
      @(negedge CLK);
      chk_zero("wait_rdy");
    end
    START = 1'b0;
    NEW_MSG = 1'b0;
    HK_RDY = 1'b1;
    K_READY = 1'b1;
    @(negedge CLK);
    chk("idle_busy", 256'(BUSY), 256'(0));

    // Block A: full H load, always-ready consumer, exact timing.
    pulse_start(1'b1, e0);
    chk("a_busy", 256'(BUSY), 256'(1));
    wait_h(e0, "a");
    chk("a_h0", 256'(H_INIT[255:224]), 256'(32'h6a09e667));
    chk("a_h7", 256'(H_INIT[31:0]), 256'(32'h5be0cd19));
    stream_k(0, -1, 1'b0, 1'b0, "a", de);
    chk("a_done_edge", 256'(de - e0), 256'(T_FULL));

    // Block B: reuse H, random backpressure, STARTs poked while busy.
    pulse_start(1'b0, e0);
    chk("b_busy", 256'(BUSY), 256'(1));
    stream_k(40, -1, 1'b1, 1'b1, "b", de);
    chk("b_h_init", H_INIT, exp_h);
    chk("b_hvld", 256'(H_VLD), 256'(1));

    // Block C: memory drops during H word 4.
    pulse_start(1'b1, e0);
    n = 0;
    while (H_ADDR !== 3'd4 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("c_reach_h4", 256'(H_ADDR), 256'(4));
    HK_RDY = 1'b0;
    @(negedge CLK);
    chk("c_abort", 256'({ABORT, H_VLD, K_VALID, BUSY}), 256'(4'b1000));
    @(negedge CLK);
    chk("c_abort_pulse", 256'(ABORT), 256'(0));
    START = 1'b1;
    NEW_MSG = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    NEW_MSG = 1'b0;
    chk("c_start_in_wait", 256'(BUSY), 256'(0));
    HK_RDY = 1'b1;
    @(negedge CLK);
    pulse_start(1'b1, e0);
    wait_h(e0, "c");
    stream_k(35, -1, 1'b0, 1'b0, "c", de);

    // Block D: memory drops while K20 is presented.
    pulse_start(1'b1, e0);
    wait_h(e0, "d");
    stream_k(30, 20, 1'b0, 1'b0, "d", de);
    chk("d_at_k20", 256'({K_VALID, K_T}), 256'({1'b1, 6'd20}));
    HK_RDY = 1'b0;
    @(negedge CLK);
    chk("d_abort", 256'({ABORT, H_VLD, K_VALID, BUSY}), 256'(4'b1000));
    @(negedge CLK);
    chk("d_abort_pulse", 256'(ABORT), 256'(0));
    HK_RDY = 1'b1;
    K_READY = 1'b1;
    @(negedge CLK);
    pulse_start(1'b1, e0);
    wait_h(e0, "d2");
    stream_k(0, -1, 1'b0, 1'b0, "d2", de);
    chk("d2_done_edge", 256'(de - e0), 256'(T_FULL));

    // Block E: reset mid-handshake at K37, then a reuse request is refused.
    pulse_start(1'b1, e0);
    wait_h(e0, "e");
    stream_k(30, 37, 1'b0, 1'b0, "e", de);
    chk("e_at_k37", 256'({K_VALID, K_T}), 256'({1'b1, 6'd37}));
    RST = 1'b0;
    @(negedge CLK);
    chk_zero("e_reset");
    RST = 1'b1;
    @(negedge CLK);
    pulse_start(1'b0, e0);
    for (int i = 0; i < 8; i++) begin
      chk("e_reuse_ignored", 256'({BUSY, H_VLD, K_VALID, HK_SEL}), 256'(0));
      @(negedge CLK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
